// File: rtl/vec_pkg.sv
// Shared vector types for the vector-add scheduler slice.
// Three signed components packed LSB-first into one word.
package vec_pkg;

   localparam int COMP_W   = 19;
   localparam int NUM_COMP = 3;
   localparam int VEC_W    = NUM_COMP * COMP_W;

   typedef logic [COMP_W-1:0] comp_t;
   typedef logic [VEC_W-1:0]  vec_t;

   function automatic comp_t comp(input vec_t v, input int k);
      return v[COMP_W*k +: COMP_W];
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: searches upward from ptr+1 with wrap.
// Produces a one-hot grant, its index and an any-grant flag.
module rr_arbiter #(
   parameter int N_REQ = 4,
   parameter int ID_W  = $clog2(N_REQ)
) (
   input  logic [N_REQ-1:0] req,
   input  logic             en,
   input  logic [ID_W-1:0]  ptr,
   output logic [N_REQ-1:0] grant,
   output logic [ID_W-1:0]  grant_idx,
   output logic             grant_any
);

   logic [ID_W-1:0] idx;

   // First requester after ptr wins; ptr itself is checked last
   always_comb begin
      grant     = '0;
      grant_idx = '0;
      grant_any = 1'b0;
      idx       = '0;
      for (int off = 1; off <= N_REQ; off++) begin
         idx = ID_W'((int'(ptr) + off) % N_REQ);
         if (en && !grant_any && req[idx]) begin
            grant_any  = 1'b1;
            grant[idx] = 1'b1;
            grant_idx  = idx;
         end
      end
   end

endmodule

// File: rtl/signed_vector_addition.sv
// Per-component two's-complement adder for packed 3-vectors.
// Each lane wraps independently; no carry crosses lanes.
module signed_vector_addition
   import vec_pkg::*;
(
   input  logic [VEC_W-1:0] a,
   input  logic [VEC_W-1:0] b,
   output logic [VEC_W-1:0] sum
);

   // Lane-wise modular add
   always_comb begin
      sum = '0;
      for (int k = 0; k < NUM_COMP; k++) begin
         sum[COMP_W*k +: COMP_W] = comp(a, k) + comp(b, k);
      end
   end

endmodule

// File: rtl/vector_add_scheduler.sv
// Shares one vector adder among N_REQ requesters, round-robin,
// with a single registered result slot and valid/ready output.
module vector_add_scheduler
   import vec_pkg::*;
#(
   parameter int N_REQ = 4,
   parameter int ID_W  = $clog2(N_REQ)
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [N_REQ-1:0]       req_valid,
   output logic [N_REQ-1:0]       req_ready,
   input  logic [N_REQ*VEC_W-1:0] req_vec_a,
   input  logic [N_REQ*VEC_W-1:0] req_vec_b,
   output logic                   rsp_valid,
   input  logic                   rsp_ready,
   output logic [VEC_W-1:0]       rsp_vec,
   output logic [ID_W-1:0]        rsp_id,
   output logic [NUM_COMP-1:0]    rsp_ovf
);

   logic                rsp_valid_q, rsp_valid_d;
   logic [VEC_W-1:0]    rsp_vec_q, rsp_vec_d;
   logic [ID_W-1:0]     rsp_id_q, rsp_id_d;
   logic [NUM_COMP-1:0] rsp_ovf_q, rsp_ovf_d;
   logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d;

   logic                slot_free;
   logic                arb_en;
   logic                accept;
   logic [ID_W-1:0]     win_idx;
   logic [VEC_W-1:0]    op_a, op_b, sum;
   logic [NUM_COMP-1:0] ovf;

   // Slot is free when empty or draining this cycle; no grants in reset
   assign slot_free = ~rsp_valid_q | rsp_ready;
   assign arb_en    = slot_free & rst_n;

   rr_arbiter #(
      .N_REQ (N_REQ),
      .ID_W  (ID_W)
   ) u_arb (
      .req       (req_valid),
      .en        (arb_en),
      .ptr       (rr_ptr_q),
      .grant     (req_ready),
      .grant_idx (win_idx),
      .grant_any (accept)
   );

   // Route the winner's operands to the shared adder
   always_comb begin
      op_a = req_vec_a[VEC_W*win_idx +: VEC_W];
      op_b = req_vec_b[VEC_W*win_idx +: VEC_W];
   end

   signed_vector_addition u_add (
      .a   (op_a),
      .b   (op_b),
      .sum (sum)
   );

   comp_t ca, cb, cs;

   // Signed overflow: like-signed operands, result sign differs
   always_comb begin
      ovf = '0;
      ca  = '0;
      cb  = '0;
      cs  = '0;
      for (int k = 0; k < NUM_COMP; k++) begin
         ca     = comp(op_a, k);
         cb     = comp(op_b, k);
         cs     = comp(sum, k);
         ovf[k] = (ca[COMP_W-1] == cb[COMP_W-1]) &
                  (cs[COMP_W-1] != ca[COMP_W-1]);
      end
   end

   // Slot update: load on accept, drain on ready, else hold
   always_comb begin
      rsp_valid_d = rsp_valid_q;
      rsp_vec_d   = rsp_vec_q;
      rsp_id_d    = rsp_id_q;
      rsp_ovf_d   = rsp_ovf_q;
      rr_ptr_d    = rr_ptr_q;
      if (accept) begin
         rsp_valid_d = 1'b1;
         rsp_vec_d   = sum;
         rsp_id_d    = win_idx;
         rsp_ovf_d   = ovf;
         rr_ptr_d    = win_idx;
      end else if (rsp_ready) begin
         rsp_valid_d = 1'b0;
      end
   end

   // Result register and arbitration pointer
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rsp_valid_q <= 1'b0;
         rsp_vec_q   <= '0;
         rsp_id_q    <= '0;
         rsp_ovf_q   <= '0;
         rr_ptr_q    <= ID_W'(N_REQ - 1);
      end else begin
         rsp_valid_q <= rsp_valid_d;
         rsp_vec_q   <= rsp_vec_d;
         rsp_id_q    <= rsp_id_d;
         rsp_ovf_q   <= rsp_ovf_d;
         rr_ptr_q    <= rr_ptr_d;
      end
   end

   assign rsp_valid = rsp_valid_q;
   assign rsp_vec   = rsp_vec_q;
   assign rsp_id    = rsp_id_q;
   assign rsp_ovf   = rsp_ovf_q;

endmodule
